usart_command_transmitter: RTL
==============================

Name: usart_command_transmitter

Overview:
- Host-side serial transmitter that produces command packets for the DAQ's USART receive path (packet merger and USART manager).
- Accepts one command/address/data tuple over a valid/ready handshake and packs it into a 48-bit message.
- Serializes the message as 6 UART 8N1 bytes on a single line.
- Used in the board-level test harness and in a host-emulation FPGA image that drives `in_sig` of the DAQ top.

Parameters:
- MSG_LENGTH, 48, message width in bits; must equal 6*8.
- COMMAND_WIDTH, 5, command field width.
- ADDRWIDTH, 8, register address field width.
- DATA_LENGTH, 32, data field width.
- CLKS_PER_BIT, 868, clock cycles per UART bit period; legal range 2..65535.
- GAP_BITS, 0, idle bit periods (line high) inserted between consecutive bytes of one message; legal range 0..15.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- i_valid  input  1  request to send a message.
- o_ready  output  1  transmitter can accept a message this cycle.
- i_command  input  COMMAND_WIDTH  command code.
- i_address  input  ADDRWIDTH  register address.
- i_data  input  DATA_LENGTH  payload.
- o_tx  output  1  UART serial line, idle high.
- o_busy  output  1  message in flight.
- o_done  output  1  one-cycle pulse when a message's last stop bit completes.

Behaviour:
- Clock and reset: one clock (`clk`). Reset is synchronous and active-high (`reset`). Reset values: o_tx=1, o_ready=1, o_busy=0, o_done=0; FSM=IDLE; all counters 0.
- Reset mid-frame: the frame is aborted with no o_done. o_tx=1 on the cycle after reset is sampled.
- Message packing on accept:
  - msg[47:43]=i_command
  - msg[42:40]=3'b000
  - msg[39:32]=i_address
  - msg[31:0]=i_data
  - Bytes are sent most-significant byte first (msg[47:40] first, msg[7:0] last).
  - Within a byte, LSB first.
- Handshake:
  - Accept occurs on a rising edge where i_valid&&o_ready. Inputs are latched; later input changes do not affect the frame in flight.
  - o_ready = (FSM==IDLE), registered.
  - i_valid while o_ready=0 is ignored; there is no queueing.
- FSM states: IDLE, START, DATA, STOP, GAP.
  - IDLE: o_tx=1. On accept -> START, loading byte_idx=0 and the shift register.
  - START: o_tx=0 for CLKS_PER_BIT cycles -> DATA with bit_idx=0.
  - DATA: o_tx=shift[bit_idx], each bit held CLKS_PER_BIT cycles. After bit 7 -> STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx==5 -> IDLE, with o_done=1 for exactly that first IDLE cycle and o_ready=1 in the same cycle;
    - else if GAP_BITS>0 -> GAP;
    - else -> START of byte_idx+1.
  - GAP: o_tx=1 for GAP_BITS*CLKS_PER_BIT cycles -> START of the next byte.
- Timing:
  - The start bit of byte 0 appears on o_tx the cycle after the accept edge (1-cycle latency).
  - Message length on the line: (60 + 5*GAP_BITS)*CLKS_PER_BIT cycles.
  - o_busy=1 from the cycle after accept through the last stop-bit cycle inclusive. o_busy=0 when o_done=1.
- Back-to-back: i_valid held high during the o_done cycle is accepted on that edge. The next start bit follows one cycle later, so minimum stop-to-start spacing is 1 extra clock.
- Counters:
  - Baud counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, and is never free-running in IDLE.
  - Gap counter counts bit periods.
- o_tx is a registered output (glitch-free).
- Simultaneous reset and i_valid: reset wins and no accept occurs.

Test Plan:
- Reset then idle: CLKS_PER_BIT=4, GAP_BITS=0, no stimulus for 100 cycles -> o_tx=1, o_ready=1, o_busy=0, o_done never asserted.
- Single message: command=5'h03, address=8'h12, data=32'hDEADBEEF, CLKS_PER_BIT=4 -> line bytes 0x18,0x12,0xDE,0xAD,0xBE,0xEF decoded by a UART monitor. Start bit at accept+1. o_done exactly 240 cycles after the first start-bit cycle.
- Gap insertion: GAP_BITS=2, CLKS_PER_BIT=4, same message -> 8 high cycles between each stop bit and the next start bit. Total frame 280 cycles. Bytes unchanged.
- Back-to-back with input change: i_valid held high with two different tuples; inputs changed mid-frame to 32'h0 -> first frame carries the original data. Second frame starts 1 cycle after o_done. Requests asserted while o_ready=0 do not create extra frames.
- Reset mid-frame: assert reset during byte 2, bit 3 -> o_tx=1 next cycle, o_busy=0, no o_done. A new accept afterwards sends a complete correct 6-byte frame.
- Minimum divider: CLKS_PER_BIT=2, message with data=32'h00000001 -> every bit 2 cycles wide. Last byte 0x01 observed LSB-first as 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/usart_command_transmitter.sv
// usart_command_transmitter
//   Packs one command/address/data tuple into a 48-bit message and sends it
//   as 6 UART 8N1 bytes, most-significant byte first, LSB first within a byte.
//   Optional idle bit periods (GAP_BITS) separate consecutive bytes.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   i_valid    request to send; accepted when i_valid && o_ready
//   o_ready    registered, high while the FSM is idle
//   i_command  command code        -> msg[47:43]
//   i_address  register address    -> msg[39:32]
//   i_data     payload             -> msg[31:0]
//   o_tx       registered UART line, idle high
//   o_busy     high from the cycle after accept through the last stop bit
//   o_done     one-cycle pulse on the first idle cycle after the last stop bit
module usart_command_transmitter #(
    parameter int MSG_LENGTH    = 48,
    parameter int COMMAND_WIDTH = 5,
    parameter int ADDRWIDTH     = 8,
    parameter int DATA_LENGTH   = 32,
    parameter int CLKS_PER_BIT  = 868,
    parameter int GAP_BITS      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [COMMAND_WIDTH-1:0] i_command,
    input  logic [ADDRWIDTH-1:0]     i_address,
    input  logic [DATA_LENGTH-1:0]   i_data,
    output logic                     o_tx,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      GAP_LAST  = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [2:0]      LAST_BYTE = 3'(MSG_LENGTH / 8 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

    state_t                state, state_n;
    logic [BW-1:0]         baud, baud_n;
    logic [2:0]            bit_idx, bit_n;
    logic [2:0]            byte_idx, byte_n;
    logic [3:0]            gap_cnt, gap_n;
    logic [MSG_LENGTH-1:0] shift, shift_n;
    logic [7:0]            cur_byte;
    logic                  done_n;
    logic                  tx_n;
    logic                  bit_end;

    assign bit_end = (baud == BAUD_LAST);

    always_comb begin
        state_n  = state;
        baud_n   = baud;
        bit_n    = bit_idx;
        byte_n   = byte_idx;
        gap_n    = gap_cnt;
        shift_n  = shift;
        done_n   = 1'b0;
        cur_byte = 8'h00;
        tx_n     = 1'b1;

        // Baud counter runs only while a frame is on the line
        if (state != IDLE)
            baud_n = bit_end ? '0 : baud + 1'b1;

        case (state)
            IDLE: begin
                baud_n = '0;
                if (i_valid && o_ready) begin
                    state_n = START;
                    byte_n  = 3'd0;
                    bit_n   = 3'd0;
                    gap_n   = 4'd0;
                    shift_n = MSG_LENGTH'({i_command, 3'b000, i_address, i_data});
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    bit_n   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx == LAST_BYTE) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        // Next byte moves into the top of the shift register
                        byte_n  = byte_idx + 3'd1;
                        shift_n = shift << 8;
                        gap_n   = 4'd0;
                        state_n = (GAP_BITS > 0) ? GAP : START;
                    end
                end
            end
            GAP: begin
                if (bit_end) begin
                    if (gap_cnt == GAP_LAST) state_n = START;
                    else                     gap_n   = gap_cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is derived from the next state so o_tx can be registered
        // without adding a cycle of latency.
        cur_byte = shift_n[MSG_LENGTH-1 -: 8];
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = cur_byte[bit_n];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 3'd0;
            gap_cnt  <= 4'd0;
            shift    <= '0;
            o_tx     <= 1'b1;
            o_ready  <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            gap_cnt  <= gap_n;
            shift    <= shift_n;
            o_tx     <= tx_n;
            o_ready  <= (state_n == IDLE);
            o_busy   <= (state_n != IDLE);
            o_done   <= done_n;
        end
    end

endmodule
